// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze sequencing controller
//
// Purpose: generates the PC, IF/ID, ID/EX and freeze controls for a 5-stage
// pipeline. It handles load-use hazards, taken branches resolved in ID and
// multi-cycle data-memory accesses. It keeps saturating stall and flush
// counters and a sticky memory-timeout error.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   start_i               run enable (level)
//   id_rs_i, id_rt_i      source register indices of the ID instruction
//   id_uses_rt_i          ID instruction reads rt
//   ex_memread_i, ex_rt_i load in EX and its destination register
//   branch_taken_i        branch/jump in ID resolved taken
//   mem_req_i, mem_ack_i  MEM-stage access outstanding / completing
//   pc_write_o            PC load enable
//   if_id_stall_o         hold IF/ID
//   if_id_flush_o         zero IF/ID instruction
//   id_ex_flush_o         bubble into ID/EX
//   pipe_freeze_o         hold ID/EX, EX/MEM, MEM/WB
//   stall_cnt_o           saturating count of stalled running cycles
//   flush_cnt_o           saturating count of IF/ID flushes
//   err_o                 sticky memory-timeout flag
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int REG_W       = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic            r_err;
    logic            w_load_use;
    logic            w_mem_stall;
    logic            w_to_full;

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use  = ex_memread_i && (ex_rt_i != '0) &&
                         ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    assign w_mem_stall = mem_req_i && !mem_ack_i;
    assign w_to_full   = (r_to_cnt == TO_W'(MEM_TIMEOUT));

    always_comb begin
        // Default is the idle/full-freeze pattern; RUN rules relax it.
        pc_write_o    = 1'b0;
        if_id_stall_o = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pipe_freeze_o = 1'b1;
        w_next_state  = r_state;
        w_to_next     = '0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next_state = S_RUN;
            end
            S_RUN: begin
                w_next_state = start_i ? S_RUN : S_IDLE;
                if (w_mem_stall) begin
                    // The issuing cycle counts as the first cycle of the wait.
                    if (start_i) begin
                        w_next_state = S_MEM_WAIT;
                        w_to_next    = TO_W'(1);
                    end
                end else if (w_load_use) begin
                    // A simultaneous taken branch is dropped; it re-resolves next cycle.
                    pipe_freeze_o = 1'b0;
                    id_ex_flush_o = 1'b1;
                end else begin
                    pc_write_o    = 1'b1;
                    if_id_stall_o = 1'b0;
                    pipe_freeze_o = 1'b0;
                    if_id_flush_o = branch_taken_i;
                end
            end
            S_MEM_WAIT: begin
                // Stopping is deferred until the outstanding access completes.
                if (mem_ack_i) begin
                    w_next_state = start_i ? S_RUN : S_IDLE;
                end else begin
                    w_to_next = w_to_full ? r_to_cnt : r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_to_cnt <= w_to_next;
            if ((r_state != S_IDLE) && !pc_write_o && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (if_id_flush_o && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if ((r_state == S_MEM_WAIT) && w_to_full)
                r_err <= 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign err_o       = r_err;

endmodule
